// File: rtl/fifo_wr_arb_2.sv
// fifo_wr_arb_2: two-producer round-robin write arbiter in front of a FIFO.
// A producer that wins keeps the write port for up to BURST consecutive
// words so its data lands contiguously; back-pressure from the FIFO freezes
// ownership without counting words. Accept is combinational, write is
// registered one cycle later.
module fifo_wr_arb_2 #(
  parameter int bw    = 8,
  parameter int BURST = 4,
  parameter int cw    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [bw-1:0] in0,
  input  logic          req1,
  input  logic [bw-1:0] in1,
  input  logic          full,
  output logic          ack0,
  output logic          ack1,
  output logic          sel,
  output logic          wr,
  output logic [bw-1:0] out,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } own_t;

  localparam logic [cw-1:0] BURST_C = cw'(BURST);

  // Bitwise AND-OR 2:1 mux: s=0 passes a, s=1 passes b.
  function automatic logic [bw-1:0] and_or_mux(input logic s,
                                               input logic [bw-1:0] a,
                                               input logic [bw-1:0] b);
    return ({bw{~s}} & a) | ({bw{s}} & b);
  endfunction

  own_t          own_p0, own_nxt, own_g;
  logic [cw-1:0] cnt_p0, cnt_nxt, cnt_inc;
  logic          rr_p0, rr_nxt;
  logic          g, gv, acc;
  logic          vld_p1, sel_p1;
  logic [bw-1:0] data_p1;

  // Grant: a current owner still requesting and under its burst limit wins,
  // otherwise round-robin on a tie, otherwise the lone requester.
  always_comb begin
    g = 1'b0;
    if (own_p0 == OWN0 && req0 && cnt_p0 < BURST_C) begin
      g = 1'b0;
    end else if (own_p0 == OWN1 && req1 && cnt_p0 < BURST_C) begin
      g = 1'b1;
    end else if (req0 && req1) begin
      g = rr_p0;
    end else begin
      g = req1;
    end
  end

  assign gv    = req0 | req1;
  assign acc   = gv & ~full & ~reset;
  assign ack0  = acc & ~g;
  assign ack1  = acc & g;
  assign own_g = g ? OWN1 : OWN0;

  // Next ownership/burst-count/priority state.
  always_comb begin
    own_nxt = own_p0;
    cnt_nxt = cnt_p0;
    rr_nxt  = rr_p0;
    cnt_inc = (own_p0 == own_g) ? cnt_p0 + cw'(1) : cw'(1);
    if (acc) begin
      if (cnt_inc == BURST_C) begin
        // Burst exhausted: hand priority to the other side.
        own_nxt = IDLE;
        cnt_nxt = '0;
        rr_nxt  = ~g;
      end else begin
        own_nxt = own_g;
        cnt_nxt = cnt_inc;
        // Owner dropped out and the other side took over directly.
        if (own_p0 != IDLE && own_p0 != own_g) rr_nxt = ~g;
      end
    end else if (!full) begin
      if (own_p0 == OWN0 && !req0) begin
        own_nxt = IDLE;
        cnt_nxt = '0;
        rr_nxt  = 1'b1;
      end else if (own_p0 == OWN1 && !req1) begin
        own_nxt = IDLE;
        cnt_nxt = '0;
        rr_nxt  = 1'b0;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_p0 <= IDLE;
      cnt_p0 <= '0;
      rr_p0  <= 1'b0;
    end else begin
      own_p0 <= own_nxt;
      cnt_p0 <= cnt_nxt;
      rr_p0  <= rr_nxt;
    end
  end

  // ---- stage p0 -> p1: accepted word registered toward the FIFO ----
  // Write strobe every accept; select and data hold when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sel_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= acc;
      if (acc) begin
        sel_p1  <= g;
        data_p1 <= and_or_mux(g, in0, in1);
      end
    end
  end

  assign wr    = vld_p1;
  assign sel   = sel_p1;
  assign out   = data_p1;
  assign owner = own_p0;

endmodule

// File: doc/fifo_wr_arb_2.md
Name: fifo_wr_arb_2

Overview:
- Round-robin write arbiter that shares one FIFO write port between two producers.
- Each cycle it chooses one requester and drives the select of the 2:1 bitwise AND-OR data mux in front of the FIFO.
- It issues a registered write strobe and data toward the FIFO and back-pressures both producers on FIFO full.
- Burst locking keeps one producer's consecutive words contiguous in the FIFO, up to BURST words per ownership.

Parameters:
- bw, 8, data width of each producer word and of the FIFO word.
- BURST, 4, maximum consecutive accepted words per ownership; legal range 1..15.
- cw, 4, width of the burst counter; must satisfy 2^cw > BURST.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  producer 0 has a word on in0.
- in0  input  bw  producer 0 data.
- req1  input  1  producer 1 has a word on in1.
- in1  input  bw  producer 1 data.
- full  input  1  FIFO cannot take a write this cycle.
- ack0  output  1  combinational; producer 0 word accepted this cycle, producer advances.
- ack1  output  1  combinational; producer 1 word accepted this cycle.
- sel  output  1  registered mux select for the accepted word (0 = in0, 1 = in1).
- wr  output  1  registered FIFO write strobe.
- out  output  bw  registered data to FIFO (the selected word).
- owner  output  2  registered ownership state: 00 IDLE, 01 OWN0, 10 OWN1.

Behaviour:
- State: owner (IDLE/OWN0/OWN1), cnt[cw-1:0], rr (1 bit, side with priority on a tie).
- Reset values: owner=IDLE, cnt=0, rr=0, wr=0, sel=0, out=0. ack0 and ack1 are forced to 0 while reset is high.
- Grant g, combinational:
  - If owner=OWNx and reqx=1 and cnt<BURST, then g=x.
  - Otherwise, if both requests are high, g=rr.
  - Otherwise, g is the single requester.
  - gv = req0 | req1.
- Accept: acc = gv & ~full. ackx = acc & (g==x).
- On an acc edge:
  - wr<=1, sel<=g, out<=(g ? in1 : in0).
  - If owner=OWNg, cnt<=cnt+1; else cnt<=1 and owner<=OWNg.
  - If the new cnt equals BURST: owner<=IDLE, cnt<=0, rr<=~g (forced handoff).
- On a cycle without acc:
  - wr<=0; sel and out hold.
  - If full=1: owner, cnt and rr hold. Ownership is kept through back-pressure, and no words are counted.
  - If full=0 and the current owner's req is low: owner<=IDLE, cnt<=0, rr<=~(owner side).
- Ownership release when the owner drops its request:
  - The drop is seen by the grant logic in the same cycle.
  - If the other side is requesting, it wins immediately via the rr/single rule, and owner switches directly.
  - In that case rr<=~g is also applied on the switch.
- Latency: ack in cycle N implies wr=1 with the matching out in cycle N+1. Back-to-back writes are allowed every cycle.
- full is sampled combinationally. When full=1, no ack and no wr is generated the next cycle. A word is never dropped or duplicated.
- BURST=1 degenerates to strict alternation when both sides request continuously.
- Reset mid-burst: all state clears asynchronously. An in-flight wr is cancelled, meaning wr drops immediately.

Test Plan:
- Reset: reset=1, req0=req1=1 -> ack0=ack1=0, wr=0, out=0, owner=00. Release reset with full=0 -> first ack is ack0.
- Single requester: req0=1 constant, in0=0x10,0x11,... for 8 cycles, BURST=4 -> ack0 every cycle, wr out 0x10..0x17 one cycle later, sel=0, no gap at burst wrap.
- Contention: req0=req1=1 continuously, BURST=4 -> grants 0,0,0,0,1,1,1,1,0... FIFO contents in order in0 x4, in1 x4.
- Back-pressure: mid-burst at cnt=2 assert full for 3 cycles -> no acks, wr=0 for those cycles. Deassert -> owner 0 finishes 2 more words, then handoff to 1.
- Early release: owner 0 drops req0 after 2 words while req1=1 -> ack1 in the same cycle, owner becomes 10, cnt=1.
- Async reset mid-burst: reset pulsed between clock edges at cnt=3 -> wr and owner clear immediately. After release, arbitration restarts with rr=0.
